hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
Pipeline hazard controller that drives the EX-stage forwarding mux select lines (XtoX_A/B, MtoX_A/B) and the load-use stall/bubble signals for the 5-stage 16-bit pipeline.
- Keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB register-tag fields (valid, rd, regwrite, memread, rs, rt, uses_rs, uses_rt). Forwarding decisions come from registered state, not from the datapath pipeline registers.
- Sits beside the ID stage. Consumes decode info plus the cache-miss freeze (mem_stall) and branch flush.

Parameters:
- REG_W, 4, register-specifier width (16 GPRs; R0 reads as zero).
- CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_W  source register A of the ID instruction.
- id_rt  input  REG_W  source register B of the ID instruction.
- id_rd  input  REG_W  destination register of the ID instruction.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_regwrite  input  1  ID instruction writes rd.
- id_memread  input  1  ID instruction is a load.
- flush  input  1  branch taken; discard the ID instruction.
- mem_stall  input  1  cache miss; freeze the whole pipeline.
- XtoX_A  output  1  EX operand A from EX/MEM ALU result.
- XtoX_B  output  1  EX operand B from EX/MEM ALU result.
- MtoX_A  output  1  EX operand A from MEM/WB write data.
- MtoX_B  output  1  EX operand B from MEM/WB write data.
- hold_if_id  output  1  hold PC and IF/ID this cycle.
- bubble_ex  output  1  this edge inserts a NOP into ID/EX.
- lu_stall_count  output  CNT_W  number of load-use stall cycles taken.

Behaviour:
- Reset (async, rst=1): all three shadow slots invalid with all fields 0. All select outputs 0, hold_if_id=0, bubble_ex=0, lu_stall_count=0. Reset mid-stall abandons the stall immediately; no pending state survives.
- Slots: EXs (ID/EX), MEMs (EX/MEM), WBs (MEM/WB).
- A slot "writes r" when valid && regwrite && rd==r && rd!=0.
- load_use (combinational) = id_valid && !flush && EXs.valid && EXs.memread && EXs.regwrite && EXs.rd!=0 && ((id_uses_rs && id_rs==EXs.rd) || (id_uses_rt && id_rt==EXs.rd)).
- hold_if_id = load_use || mem_stall.
- bubble_ex = !mem_stall && (load_use || flush || !id_valid).
- Clock edge, mem_stall=1: every slot holds, counter holds.
- Clock edge, mem_stall=0:
  - WBs <= MEMs, then MEMs <= EXs.
  - EXs <= bubble (valid=0) if bubble_ex, else the id_* fields with valid=1.
- Flush beats load_use: a flushed instruction never stalls.
- A load-use stall lasts exactly one advancing cycle. The next cycle the load is in MEMs and the dependent instruction is served by MtoX one cycle after that.
- Forward selects are combinational from registered slots only, so they are glitch-free relative to the ID inputs:
  - XtoX_A = EXs.valid && EXs.uses_rs && MEMs writes EXs.rs && !MEMs.memread.
  - MtoX_A = EXs.valid && EXs.uses_rs && WBs writes EXs.rs && !XtoX_A.
  - XtoX_B / MtoX_B: same, using rt and uses_rt.
  - The youngest producer wins: XtoX has priority over MtoX, and XtoX and MtoX for the same operand are never both 1.
  - R0 is never forwarded.
  - If EXs is a bubble, all selects are 0.
- During mem_stall, selects stay stable because slots are frozen.
- lu_stall_count increments by 1 on each edge where load_use && !mem_stall. It saturates at all-ones.
- No WB-to-ID bypass here; the register file is write-before-read.

Test Plan:
- Reset release, then ADD R1,R2,R3 followed by SUB R4,R1,R5:
  - Cycle SUB is in EX: XtoX_A=1, MtoX_A=0, others 0.
  - Next cycle: all 0.
- ADD R1 / NOP / SUB R4,R5,R1 -> MtoX_B=1 only.
- ADD R1 and ADD R1 back-to-back, then SUB R6,R1,R1:
  - XtoX_A=XtoX_B=1, MtoX_A=MtoX_B=0 (youngest wins).
- LW R2 followed by ADD R3,R2,R4:
  - First cycle: hold_if_id=1, bubble_ex=1, lu_stall_count 0→1.
  - Next cycle: no hold.
  - When ADD reaches EX: MtoX_A=1.
- Load-use coincident with flush=1 -> hold_if_id=0, bubble_ex=1, counter unchanged.
- Load-use coincident with mem_stall=1 for 5 cycles:
  - Slots frozen, counter unchanged, hold_if_id=1 throughout.
  - After mem_stall drops: one stall cycle, counter +1.
  - Assert rst mid-sequence -> all outputs 0 immediately.
- Writes to R0 (ADD R0 followed by SUB R1,R0,R0) -> no forwarding and no stall.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// EX-stage forwarding selects and load-use stall/bubble control from shadow copies of the pipeline register tags.
// Selects are combinational from registered slots; hold/bubble are combinational from ID inputs; mem_stall freezes all state.
module hazard_forward_ctrl #(
   parameter int REG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             flush,
   input  logic             mem_stall,
   output logic             XtoX_A,
   output logic             XtoX_B,
   output logic             MtoX_A,
   output logic             MtoX_B,
   output logic             hold_if_id,
   output logic             bubble_ex,
   output logic [CNT_W-1:0] lu_stall_count
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic             regwrite;
      logic             memread;
      logic             uses_rs;
      logic             uses_rt;
   } slot_t;

   slot_t ex_s;
   slot_t mem_s;
   slot_t wb_s;
   slot_t id_s;
   logic  load_use;

   function automatic logic writes(input slot_t s, input logic [REG_W-1:0] r);
      return s.valid && s.regwrite && (s.rd == r) && (s.rd != '0);
   endfunction

   always_comb begin
      id_s          = '0;
      id_s.valid    = 1'b1;
      id_s.rd       = id_rd;
      id_s.rs       = id_rs;
      id_s.rt       = id_rt;
      id_s.regwrite = id_regwrite;
      id_s.memread  = id_memread;
      id_s.uses_rs  = id_uses_rs;
      id_s.uses_rt  = id_uses_rt;
   end

   assign load_use = id_valid && !flush && ex_s.valid && ex_s.memread &&
                     ((id_uses_rs && writes(ex_s, id_rs)) ||
                      (id_uses_rt && writes(ex_s, id_rt)));

   // Gated by rst so that every output reads 0 while reset is held.
   assign hold_if_id = !rst && (load_use || mem_stall);
   assign bubble_ex  = !rst && !mem_stall && (load_use || flush || !id_valid);

   assign XtoX_A = ex_s.valid && ex_s.uses_rs && writes(mem_s, ex_s.rs) && !mem_s.memread;
   assign XtoX_B = ex_s.valid && ex_s.uses_rt && writes(mem_s, ex_s.rt) && !mem_s.memread;
   assign MtoX_A = ex_s.valid && ex_s.uses_rs && writes(wb_s, ex_s.rs) && !XtoX_A;
   assign MtoX_B = ex_s.valid && ex_s.uses_rt && writes(wb_s, ex_s.rt) && !XtoX_B;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_s           <= '0;
         mem_s          <= '0;
         wb_s           <= '0;
         lu_stall_count <= '0;
      end else if (!mem_stall) begin
         wb_s  <= mem_s;
         mem_s <= ex_s;
         ex_s  <= bubble_ex ? slot_t'('0) : id_s;
         if (load_use && (lu_stall_count != '1))
            lu_stall_count <= lu_stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboarded bench for hazard_forward_ctrl: directed pipeline scenarios plus a random hazard mix.
module tb_hazard_forward_ctrl;
   localparam int REG_W   = 4;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid;
   logic [REG_W-1:0] id_rs, id_rt, id_rd;
   logic             id_uses_rs, id_uses_rt, id_regwrite, id_memread;
   logic             flush, mem_stall;
   logic             XtoX_A, XtoX_B, MtoX_A, MtoX_B;
   logic             hold_if_id, bubble_ex;
   logic [CNT_W-1:0] lu_stall_count;

   hazard_forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .flush(flush), .mem_stall(mem_stall),
      .XtoX_A(XtoX_A), .XtoX_B(XtoX_B), .MtoX_A(MtoX_A), .MtoX_B(MtoX_B),
      .hold_if_id(hold_if_id), .bubble_ex(bubble_ex),
      .lu_stall_count(lu_stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       v;
      bit [3:0] rd, rs, rt;
      bit       rw, mr, urs, urt;
   } mslot_t;

   // sel = {XtoX_A, XtoX_B, MtoX_A, MtoX_B, hold_if_id, bubble_ex}
   typedef struct {
      logic [5:0]       sel;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   mslot_t m_ex, m_mem, m_wb;
   int     m_cnt;
   exp_t   sb[$];
   int     n_cmp = 0;
   int     n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic mslot_t empty_slot();
      mslot_t s;
      s = '{default: 0};
      return s;
   endfunction

   task automatic model_reset();
      m_ex  = empty_slot();
      m_mem = empty_slot();
      m_wb  = empty_slot();
      m_cnt = 0;
   endtask

   function automatic bit model_lu();
      bit dep;
      dep = (id_uses_rs && id_rs == m_ex.rd) || (id_uses_rt && id_rt == m_ex.rd);
      return id_valid && !flush && m_ex.v && m_ex.mr && m_ex.rw && (m_ex.rd != 0) && dep;
   endfunction

   // Returns {from EX/MEM, from MEM/WB} for one EX operand.
   function automatic bit [1:0] model_fwd(input bit opb);
      bit [3:0] src;
      bit       used;
      src  = opb ? m_ex.rt : m_ex.rs;
      used = opb ? m_ex.urt : m_ex.urs;
      if (!m_ex.v || !used || src == 0) return 2'b00;
      if (m_mem.v && m_mem.rw && m_mem.rd == src && !m_mem.mr) return 2'b10;
      if (m_wb.v && m_wb.rw && m_wb.rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t model_out();
      exp_t     e;
      bit [1:0] a, b;
      bit       lu;
      lu    = model_lu();
      a     = model_fwd(1'b0);
      b     = model_fwd(1'b1);
      e.sel = {a[1], b[1], a[0], b[0], lu || mem_stall, !mem_stall && (lu || flush || !id_valid)};
      e.cnt = m_cnt[CNT_W-1:0];
      return e;
   endfunction

   task automatic model_edge();
      bit lu;
      mslot_t nxt;
      if (!mem_stall) begin
         lu = model_lu();
         if (lu && m_cnt < CNT_MAX) m_cnt++;
         nxt = empty_slot();
         if (!(lu || flush || !id_valid)) begin
            nxt.v  = 1; nxt.rd = id_rd; nxt.rs = id_rs; nxt.rt = id_rt;
            nxt.rw = id_regwrite; nxt.mr = id_memread;
            nxt.urs = id_uses_rs; nxt.urt = id_uses_rt;
         end
         m_wb  = m_mem;
         m_mem = m_ex;
         m_ex  = nxt;
      end
   endtask

   task automatic cyc();
      exp_t e, g;
      sb.push_back(model_out());
      @(negedge clk);
      g.sel = {XtoX_A, XtoX_B, MtoX_A, MtoX_B, hold_if_id, bubble_ex};
      g.cnt = lu_stall_count;
      e = sb.pop_front();
      check("sb_sel", 32'(g.sel), 32'(e.sel));
      check("sb_cnt", 32'(g.cnt), 32'(e.cnt));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic ins(input int rd, input int rs, input int rt, input bit urs, input bit urt,
                      input bit rw, input bit mr);
      id_valid = 1; id_rd = 4'(rd); id_rs = 4'(rs); id_rt = 4'(rt);
      id_uses_rs = urs; id_uses_rt = urt; id_regwrite = rw; id_memread = mr;
      flush = 0; mem_stall = 0;
   endtask

   task automatic nop();
      id_valid = 0; id_rd = 0; id_rs = 0; id_rt = 0;
      id_uses_rs = 0; id_uses_rt = 0; id_regwrite = 0; id_memread = 0;
      flush = 0; mem_stall = 0;
   endtask

   task automatic drain();
      nop();
      repeat (3) cyc();
   endtask

   task automatic sel_is(input string tag, input logic [3:0] exp);
      check(tag, 32'({XtoX_A, XtoX_B, MtoX_A, MtoX_B}), 32'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1;
      nop();
      model_reset();
      #12;
      check("rst_outs", 32'({XtoX_A, XtoX_B, MtoX_A, MtoX_B, hold_if_id, bubble_ex}), 32'h0);
      check("rst_cnt", 32'(lu_stall_count), 32'h0);
      @(negedge clk) rst = 0;
      @(posedge clk); #1;

      // ADD R1,R2,R3 ; SUB R4,R1,R5
      ins(1, 2, 3, 1, 1, 1, 0); cyc();
      ins(4, 1, 5, 1, 1, 1, 0); cyc();
      nop(); #1;
      sel_is("xtox_a", 4'b1000);
      cyc();
      sel_is("xtox_a_next", 4'b0000);
      drain();

      // ADD R1 ; NOP ; SUB R4,R5,R1
      ins(1, 2, 3, 1, 1, 1, 0); cyc();
      nop(); cyc();
      ins(4, 5, 1, 1, 1, 1, 0); cyc();
      nop(); #1;
      sel_is("mtox_b", 4'b0001);
      drain();

      // ADD R1 ; ADD R1 ; SUB R6,R1,R1
      ins(1, 2, 3, 1, 1, 1, 0); cyc();
      ins(1, 2, 3, 1, 1, 1, 0); cyc();
      ins(6, 1, 1, 1, 1, 1, 0); cyc();
      nop(); #1;
      sel_is("youngest", 4'b1100);
      drain();

      // LW R2 ; ADD R3,R2,R4
      ins(2, 7, 0, 1, 0, 1, 1); cyc();
      ins(3, 2, 4, 1, 1, 1, 0); #1;
      check("lu_hold", 32'(hold_if_id), 32'd1);
      check("lu_bubble", 32'(bubble_ex), 32'd1);
      check("lu_cnt0", 32'(lu_stall_count), 32'd0);
      cyc();
      check("lu_cnt1", 32'(lu_stall_count), 32'd1);
      check("lu_nohold", 32'(hold_if_id), 32'd0);
      check("lu_nobubble", 32'(bubble_ex), 32'd0);
      cyc();
      nop(); #1;
      sel_is("lu_mtox", 4'b0010);
      drain();

      // Load-use under flush
      ins(2, 7, 0, 1, 0, 1, 1); cyc();
      ins(3, 2, 4, 1, 1, 1, 0); flush = 1; #1;
      check("fl_hold", 32'(hold_if_id), 32'd0);
      check("fl_bubble", 32'(bubble_ex), 32'd1);
      cyc();
      check("fl_cnt", 32'(lu_stall_count), 32'd1);
      nop(); #1;
      sel_is("fl_sel", 4'b0000);
      drain();

      // Load-use under a 5-cycle cache miss
      ins(2, 7, 0, 1, 0, 1, 1); cyc();
      ins(3, 2, 4, 1, 1, 1, 0); mem_stall = 1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("ms_hold", 32'(hold_if_id), 32'd1);
         check("ms_cnt", 32'(lu_stall_count), 32'd1);
      end
      mem_stall = 0; #1;
      check("ms_bubble", 32'(bubble_ex), 32'd1);
      cyc();
      check("ms_cnt2", 32'(lu_stall_count), 32'd2);
      check("ms_nohold", 32'(hold_if_id), 32'd0);
      drain();

      // Reset in the middle of a frozen load-use
      ins(2, 7, 0, 1, 0, 1, 1); cyc();
      ins(3, 2, 4, 1, 1, 1, 0); mem_stall = 1;
      cyc(); cyc();
      rst = 1; #1;
      check("mid_rst_outs", 32'({XtoX_A, XtoX_B, MtoX_A, MtoX_B, hold_if_id, bubble_ex}), 32'h0);
      check("mid_rst_cnt", 32'(lu_stall_count), 32'h0);
      model_reset();
      nop();
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      check("post_rst_hold", 32'(hold_if_id), 32'd0);
      check("post_rst_cnt", 32'(lu_stall_count), 32'd0);

      // R0 is never a hazard
      ins(0, 2, 3, 1, 1, 1, 0); cyc();
      ins(1, 0, 0, 1, 1, 1, 0); #1;
      check("r0_nohold", 32'(hold_if_id), 32'd0);
      cyc();
      nop(); #1;
      sel_is("r0_sel", 4'b0000);
      ins(0, 7, 0, 1, 0, 1, 1); cyc();
      ins(3, 0, 0, 1, 1, 1, 0); #1;
      check("r0_lw_nohold", 32'(hold_if_id), 32'd0);
      cyc();
      drain();

      // Random mix with a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         id_valid    = ($urandom_range(0, 3) != 0);
         id_rd       = 4'($urandom_range(0, 3));
         id_rs       = 4'($urandom_range(0, 3));
         id_rt       = 4'($urandom_range(0, 3));
         id_uses_rs  = 1'($urandom_range(0, 1));
         id_uses_rt  = 1'($urandom_range(0, 1));
         id_regwrite = ($urandom_range(0, 3) != 0);
         id_memread  = ($urandom_range(0, 2) == 0);
         flush       = ($urandom_range(0, 7) == 0);
         mem_stall   = ($urandom_range(0, 5) == 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
